// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared defaults, fill-count width helper and error-flag type
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DEPTH_P2_DEF = 5;

  // A count of 0..depth needs one bit more than the address.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ram_2p.sv
// ============================================================================
// fifo_ram_2p : WIDTH x DEPTH storage, one write port, one asynchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_ram_2p #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram_2p

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
// ============================================================================
// sync_fifo_flags : single-clock FWFT FIFO with fill count, thresholds,
//                   flush and sticky overflow/underflow flags
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH_P2  = DEPTH_P2_DEF,
  parameter int AF_THRESH = 2**DEPTH_P2 - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [WIDTH-1:0]                       data_in,
  input  logic                                   put,
  input  logic                                   get,
  output logic [WIDTH-1:0]                       data_out,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   almost_empty,
  output logic                                   almost_full,
  output logic [fill_width(2**DEPTH_P2)-1:0]     fillcount,
  output logic                                   overflow,
  output logic                                   underflow
);

  localparam int DEPTH = 2**DEPTH_P2;
  localparam int CW    = fill_width(DEPTH);

  if (DEPTH_P2 < 1) begin : g_chk_depth
    $error("sync_fifo_flags: DEPTH_P2 must be >= 1");
  end
  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_chk_thresh
    $error("sync_fifo_flags: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DEPTH_P2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_P2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  fifo_err_t           err_q,    err_d;

  logic wen;
  logic ren;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wen   = put & ~full;
  assign ren   = get & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (wen) wr_ptr_d = wr_ptr_q + 1'b1;
      if (ren) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wen, ren})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      err_d.overflow  = err_q.overflow  | (put & full);
      err_d.underflow = err_q.underflow | (get & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Writes are suppressed on reset/flush edges so a discarded put never lands.
  fifo_ram_2p #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_P2)
  ) u_ram (
    .clk     (clk),
    .we_i    (wen & ~flush & reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign fillcount    = count_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule : sync_fifo_flags

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// ============================================================================
// tb_sync_fifo_flags : directed self-checking bench for sync_fifo_flags
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] data_in = '0;
  logic       put = 1'b0;
  logic       get = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, almost_empty, almost_full;
  logic [5:0] fillcount;
  logic       overflow, underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo_flags dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .data_in      (data_in),
    .put          (put),
    .get          (get),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fillcount    (fillcount),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    total++; if ({fillcount, empty, full, almost_empty, almost_full, overflow, underflow} !== {6'd0, 6'b101000})
      $display("FAIL reset_state: got fc=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want fc=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
               fillcount, empty, full, almost_empty, almost_full, overflow, underflow);
    else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      put = 1'b1; data_in = 8'(i);
      step();
      total++; if (fillcount !== 6'(i + 1))
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, fillcount, i + 1);
      else passed++;
      total++; if (almost_full !== (i + 1 >= 28))
        $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 28));
      else passed++;
      total++; if (full !== (i + 1 == 32))
        $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i + 1 == 32));
      else passed++;
      total++; if (data_out !== 8'h00)
        $display("FAIL fill_head[%0d]: got %h want 00", i, data_out);
      else passed++;
    end
    put = 1'b0;
  endtask

  task automatic test_overflow_drain();
    put = 1'b1; data_in = 8'hAA;
    step();
    put = 1'b0;
    total++; if (overflow !== 1'b1 || fillcount !== 6'd32)
      $display("FAIL overflow_set: got ov=%b fc=%0d want ov=1 fc=32", overflow, fillcount);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      total++; if (data_out !== 8'(i))
        $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, 8'(i));
      else passed++;
      get = 1'b1;
      step();
      total++; if (fillcount !== 6'(31 - i) || almost_empty !== (31 - i <= 4) || empty !== (i == 31))
        $display("FAIL drain_flags[%0d]: got fc=%0d ae=%b e=%b want fc=%0d ae=%b e=%b",
                 i, fillcount, almost_empty, empty, 31 - i, (31 - i <= 4), (i == 31));
      else passed++;
    end
    get = 1'b0;
    total++; if (overflow !== 1'b1 || underflow !== 1'b0)
      $display("FAIL overflow_sticky: got ov=%b un=%b want ov=1 un=0", overflow, underflow);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] v;
    // Move both pointers to 20 so the streaming phase wraps past entry 31.
    for (int i = 0; i < 20; i++) begin put = 1'b1; data_in = 8'(i); step(); end
    put = 1'b0;
    for (int i = 0; i < 20; i++) begin get = 1'b1; step(); end
    get = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 8'h40 + 8'(i); put = 1'b1; data_in = v; q.push_back(v); step();
    end
    for (int i = 0; i < 20; i++) begin
      v = 8'h80 + 8'(i);
      total++; if (data_out !== q[0])
        $display("FAIL b2b_data[%0d]: got %h want %h", i, data_out, q[0]);
      else passed++;
      put = 1'b1; get = 1'b1; data_in = v;
      void'(q.pop_front()); q.push_back(v);
      step();
      total++; if (fillcount !== 6'd10)
        $display("FAIL b2b_count[%0d]: got %0d want 10", i, fillcount);
      else passed++;
    end
    put = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (data_out !== q[0])
        $display("FAIL b2b_tail[%0d]: got %h want %h", i, data_out, q[0]);
      else passed++;
      void'(q.pop_front());
      get = 1'b1; step();
    end
    get = 1'b0;
    total++; if (empty !== 1'b1)
      $display("FAIL b2b_empty: got %b want 1", empty);
    else passed++;
  endtask

  task automatic test_underflow();
    put = 1'b1; get = 1'b1; data_in = 8'h5C;
    step();
    put = 1'b0; get = 1'b0;
    total++; if (underflow !== 1'b1 || fillcount !== 6'd1 || data_out !== 8'h5C)
      $display("FAIL underflow_put_get: got un=%b fc=%0d do=%h want un=1 fc=1 do=5c", underflow, fillcount, data_out);
    else passed++;
    get = 1'b1; step(); get = 1'b0;
    total++; if (empty !== 1'b1 || underflow !== 1'b1)
      $display("FAIL underflow_sticky: got e=%b un=%b want e=1 un=1", empty, underflow);
    else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) begin put = 1'b1; data_in = 8'h90 + 8'(i); step(); end
    flush = 1'b1; data_in = 8'hEE;
    step();
    flush = 1'b0; put = 1'b0;
    total++; if ({fillcount, empty, overflow, underflow} !== {6'd0, 3'b100})
      $display("FAIL flush_state: got fc=%0d e=%b ov=%b un=%b want fc=0 e=1 ov=0 un=0", fillcount, empty, overflow, underflow);
    else passed++;
    put = 1'b1; data_in = 8'h33; step(); put = 1'b0;
    total++; if (fillcount !== 6'd1 || data_out !== 8'h33)
      $display("FAIL flush_restart: got fc=%0d do=%h want fc=1 do=33", fillcount, data_out);
    else passed++;
    get = 1'b1; step(); get = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin put = 1'b1; data_in = 8'hC0 + 8'(i); step(); end
    put = 1'b0; get = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; get = 1'b0;
    total++; if (fillcount !== 6'd0 || empty !== 1'b1 || underflow !== 1'b0)
      $display("FAIL reset_mid: got fc=%0d e=%b un=%b want fc=0 e=1 un=0", fillcount, empty, underflow);
    else passed++;
    put = 1'b1; data_in = 8'h11; step();
    data_in = 8'h22; step();
    put = 1'b0;
    total++; if (fillcount !== 6'd2 || data_out !== 8'h11)
      $display("FAIL reset_restart_a: got fc=%0d do=%h want fc=2 do=11", fillcount, data_out);
    else passed++;
    get = 1'b1; step(); get = 1'b0;
    total++; if (fillcount !== 6'd1 || data_out !== 8'h22 || overflow !== 1'b0)
      $display("FAIL reset_restart_b: got fc=%0d do=%h ov=%b want fc=1 do=22 ov=0", fillcount, data_out, overflow);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sync_fifo_flags

`default_nettype wire
